// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment display scheduler.
//   seg7_sched_st_e : scheduler state (IDLE / SHOW / ALERT)
//   SEG7_BLANK      : driver payload with every segment off
//   SEG7_MODE_HEX   : driver interprets data as hex nibbles
//   SEG7_MODE_RAW   : driver interprets data as raw segment bytes
//   max2()          : elaboration-time maximum of two ints
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALERT = 2'd2
  } seg7_sched_st_e;

  localparam logic [63:0] SEG7_BLANK    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        SEG7_MODE_HEX = 1'b0;
  localparam logic        SEG7_MODE_RAW = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_disp_sched_rr_next_sel.sv
// ---------------------------------------------------------------------------
// rr_next_sel
// Combinational round-robin finder. Scans valid[] starting at index 'start'
// (inclusive) and wrapping modulo N; reports the first set index.
// Ports:
//   valid    in  N   : request vector
//   start    in  IW  : first index to examine
//   next_idx out IW  : first valid index found (0 when none)
//   found    out 1   : at least one valid bit was set
// ---------------------------------------------------------------------------
module rr_next_sel #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] next_idx,
  output logic          found
);

  always_comb begin
    int            k;
    logic [IW-1:0] idx;
    // NOTE: every variable driven here gets a default first, so no path
    // leaves a value held over and no latch is inferred.
    k        = 0;
    idx      = '0;
    next_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      idx = IW'(k);
      if (!found && valid[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// ---------------------------------------------------------------------------
// seg7_disp_sched
// Shares one 64-bit seven-segment display between NSRC requesters. Valid
// sources are shown in turn (dwell timer or btn_next); a one-shot alert
// pre-empts the rotation for ALERT_HOLD cycles.
//
// Build option: define SEG7_AUTOSCROLL_EN to include the dwell timer
// (auto-advance, freeze). Without it the selection moves only on btn_next
// or when the current source drops its valid.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   src_valid  [NSRC]      per-source display request (level)
//   src_data   [64*NSRC]   source k in bits [64k+63:64k]
//   src_mode   [NSRC]      per-source mode (0 hex, 1 raw)
//   btn_next               pulse: next source / dismiss alert
//   freeze                 level: pause dwell counter
//   alert_req              pulse: capture alert payload and pre-empt
//   alert_data [64], alert_mode
//   disp_data  [64], disp_mode      registered, to the driver
//   cur_src    [clog2(NSRC)]        registered selected index
//   alert_active                    registered, high in ALERT
//   src_ack    [NSRC]               one-hot pulse on new selection
// ---------------------------------------------------------------------------
module seg7_disp_sched
  import seg7_pkg::*;
#(
  parameter  int NSRC       = 4,
  parameter  int DWELL      = 50_000_000,
  parameter  int ALERT_HOLD = 100_000_000,
  localparam int IW         = $clog2(NSRC)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [64*NSRC-1:0] src_data,
  input  logic [NSRC-1:0]    src_mode,
  input  logic               btn_next,
  input  logic               freeze,
  input  logic               alert_req,
  input  logic [63:0]        alert_data,
  input  logic               alert_mode,
  output logic [63:0]        disp_data,
  output logic               disp_mode,
  output logic [IW-1:0]      cur_src,
  output logic               alert_active,
  output logic [NSRC-1:0]    src_ack
);

  localparam int CW = $clog2(max2(DWELL, ALERT_HOLD));

  seg7_sched_st_e  state, state_nxt;
  logic [IW-1:0]   cur_nxt, fwd_start, fwd_idx, low_idx;
  logic            fwd_found, low_found;
  logic            ack_en, dwell_clr, adv;
  logic            dwell_done, hold_done;
  logic [CW-1:0]   hold_cnt;
  logic [63:0]     disp_data_nxt, sel_data;
  logic            disp_mode_nxt, sel_mode, alert_active_nxt;
  logic [NSRC-1:0] src_ack_nxt;

  // Advance search starts one past the current source, wrapping.
  assign fwd_start = (cur_src == IW'(NSRC - 1)) ? '0 : cur_src + 1'b1;

  rr_next_sel #(.N(NSRC)) u_fwd_sel (
    .valid    (src_valid),
    .start    (fwd_start),
    .next_idx (fwd_idx),
    .found    (fwd_found)
  );

  rr_next_sel #(.N(NSRC)) u_low_sel (
    .valid    (src_valid),
    .start    ('0),
    .next_idx (low_idx),
    .found    (low_found)
  );

  // Output mux follows the next selection so data and ack land together.
  assign sel_data = src_data[{cur_nxt, 6'b0} +: 64];
  assign sel_mode = src_mode[cur_nxt];

`ifdef SEG7_AUTOSCROLL_EN
  logic [CW-1:0] dwell_cnt;

  // Expiry is masked while frozen so freeze stretches the dwell exactly.
  assign dwell_done = (state == ST_SHOW) && !freeze && (dwell_cnt == CW'(DWELL - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                         dwell_cnt <= '0;
    else if (dwell_clr)                                dwell_cnt <= '0;
    else if (state == ST_SHOW && !freeze && !dwell_done) dwell_cnt <= dwell_cnt + 1'b1;
  end
`else
  logic unused_dwell;
  assign unused_dwell = freeze ^ dwell_clr;
  assign dwell_done   = 1'b0;
`endif

  assign hold_done = (hold_cnt == CW'(ALERT_HOLD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                     hold_cnt <= '0;
    else if (alert_req)                            hold_cnt <= '0;
    else if (state == ST_ALERT && !hold_done)      hold_cnt <= hold_cnt + 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state        <= ST_IDLE;
      cur_src      <= '0;
      disp_data    <= SEG7_BLANK;
      disp_mode    <= SEG7_MODE_RAW;
      alert_active <= 1'b0;
      src_ack      <= '0;
    end else begin
      state        <= state_nxt;
      cur_src      <= cur_nxt;
      disp_data    <= disp_data_nxt;
      disp_mode    <= disp_mode_nxt;
      alert_active <= alert_active_nxt;
      src_ack      <= src_ack_nxt;
    end
  end

  // Next-state and selection decision.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_src;
    ack_en    = 1'b0;
    dwell_clr = 1'b0;
    adv       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alert_req) begin
          state_nxt = ST_ALERT;
        end else if (low_found) begin
          state_nxt = ST_SHOW;
          cur_nxt   = low_idx;
          ack_en    = 1'b1;
          dwell_clr = 1'b1;
        end
      end
      ST_SHOW: begin
        if (alert_req)                                        state_nxt = ST_ALERT;
        else if (!src_valid[cur_src] || btn_next || dwell_done) adv = 1'b1;
      end
      ST_ALERT: begin
        // A repeated alert_req simply stays here; it outranks btn_next.
        if (!alert_req && (hold_done || btn_next)) begin
          if (src_valid[cur_src]) begin
            state_nxt = ST_SHOW;
            dwell_clr = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (adv) begin
      if (!fwd_found) begin
        state_nxt = ST_IDLE;
      end else begin
        // Wrapping back onto cur_src means it is the only valid source.
        state_nxt = ST_SHOW;
        cur_nxt   = fwd_idx;
        ack_en    = (fwd_idx != cur_src);
        dwell_clr = 1'b1;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    disp_data_nxt    = disp_data;
    disp_mode_nxt    = disp_mode;
    alert_active_nxt = (state_nxt == ST_ALERT);
    src_ack_nxt      = '0;
    case (state_nxt)
      ST_SHOW: begin
        disp_data_nxt = sel_data;
        disp_mode_nxt = sel_mode;
      end
      ST_ALERT: begin
        if (alert_req) begin
          disp_data_nxt = alert_data;
          disp_mode_nxt = alert_mode;
        end
      end
      default: begin
        disp_data_nxt = SEG7_BLANK;
        disp_mode_nxt = SEG7_MODE_RAW;
      end
    endcase
    if (ack_en) src_ack_nxt[cur_nxt] = 1'b1;
  end

endmodule

// File: tb/tb_seg7_disp_sched.sv
// ---------------------------------------------------------------------------
// tb_seg7_disp_sched
// Directed bench for seg7_disp_sched with NSRC=4, DWELL=4, ALERT_HOLD=6.
// A vector table covers reset, rotation, freeze, manual advance and source
// drops; hand-written sequences cover alerts and a mid-alert reset.
// Expectations for dwell-driven steps follow SEG7_AUTOSCROLL_EN.
// ---------------------------------------------------------------------------
module tb_seg7_disp_sched;
  import seg7_pkg::*;

  localparam int NSRC       = 4;
  localparam int DWELL      = 4;
  localparam int ALERT_HOLD = 6;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NSRC-1:0]    src_valid;
  logic [64*NSRC-1:0] src_data;
  logic [NSRC-1:0]    src_mode;
  logic               btn_next;
  logic               freeze;
  logic               alert_req;
  logic [63:0]        alert_data;
  logic               alert_mode;
  logic [63:0]        disp_data;
  logic               disp_mode;
  logic [1:0]         cur_src;
  logic               alert_active;
  logic [NSRC-1:0]    src_ack;

  seg7_disp_sched #(
    .NSRC       (NSRC),
    .DWELL      (DWELL),
    .ALERT_HOLD (ALERT_HOLD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_mode     (src_mode),
    .btn_next     (btn_next),
    .freeze       (freeze),
    .alert_req    (alert_req),
    .alert_data   (alert_data),
    .alert_mode   (alert_mode),
    .disp_data    (disp_data),
    .disp_mode    (disp_mode),
    .cur_src      (cur_src),
    .alert_active (alert_active),
    .src_ack      (src_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] modes = 4'b1010;

  localparam logic [63:0] A1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] A2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] A3 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] A4 = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] A5 = 64'h0F0F_0F0F_F0F0_F0F0;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       btn;
    logic       frz;
    logic       blank;
    int         src;
    logic [3:0] ack;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] data_of(input int k);
    logic [7:0] b;
    b = 8'hA0 | 8'(k);
    return {8{b}};
  endfunction

  function automatic void add(input logic rst, input logic [3:0] vld, input logic btn,
                              input logic frz, input logic blank, input int src,
                              input logic [3:0] ack, input string name);
    vec_t v;
    v.rst = rst; v.vld = vld; v.btn = btn; v.frz = frz;
    v.blank = blank; v.src = src; v.ack = ack; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_show(input string name, input logic blank, input int src,
                            input logic [3:0] ack);
    logic [1:0] s;
    s = 2'(src);
    if (blank) begin
      check({name, ".data"}, disp_data, SEG7_BLANK);
      check({name, ".mode"}, 64'(disp_mode), 64'(SEG7_MODE_RAW));
    end else begin
      check({name, ".data"}, disp_data, data_of(src));
      check({name, ".mode"}, 64'(disp_mode), 64'(modes[s]));
      check({name, ".cur"},  64'(cur_src),   64'(s));
    end
    check({name, ".ack"},   64'(src_ack),      64'(ack));
    check({name, ".alert"}, 64'(alert_active), 64'(0));
  endtask

  task automatic check_alert(input string name, input logic [63:0] data, input logic mode);
    check({name, ".data"},  disp_data,          data);
    check({name, ".mode"},  64'(disp_mode),     64'(mode));
    check({name, ".alert"}, 64'(alert_active),  64'(1));
    check({name, ".ack"},   64'(src_ack),       64'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    src_valid  = '0;
    btn_next   = 1'b0;
    freeze     = 1'b0;
    alert_req  = 1'b0;
    alert_data = '0;
    alert_mode = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NSRC; k++) src_data[64*k +: 64] = data_of(k);
    src_mode = modes;

    // Reset and empty
    add(1, 4'b0000, 0, 0, 1, 0, 4'b0000, "reset");
    add(0, 4'b0000, 0, 0, 1, 0, 4'b0000, "idle_empty");
    // Rotation over 4'b1011, then one frozen cycle
    add(0, 4'b1011, 0, 0, 0, 0, 4'b0001, "rot_first");
`ifdef SEG7_AUTOSCROLL_EN
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 0, 0, 0, 4'b0000, "rot_s0");
    add(0, 4'b1011, 0, 0, 0, 1, 4'b0010, "rot_to_s1");
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 0, 0, 1, 4'b0000, "rot_s1");
    add(0, 4'b1011, 0, 0, 0, 3, 4'b1000, "rot_to_s3");
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 0, 0, 3, 4'b0000, "rot_s3");
    add(0, 4'b1011, 0, 0, 0, 0, 4'b0001, "rot_wrap");
    add(0, 4'b1011, 0, 1, 0, 0, 4'b0000, "frz_hold");
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 0, 0, 0, 4'b0000, "frz_s0");
    add(0, 4'b1011, 0, 0, 0, 1, 4'b0010, "frz_adv");
`else
    for (int i = 0; i < 17; i++) add(0, 4'b1011, 0, (i == 12), 0, 0, 4'b0000, "rot_none");
`endif
    // Manual advance, single source, dwell restart
    add(1, 4'b0000, 0, 0, 1, 0, 4'b0000, "reset2");
    add(0, 4'b0110, 0, 0, 0, 1, 4'b0010, "man_first");
    add(0, 4'b0110, 1, 0, 0, 2, 4'b0100, "man_btn");
    add(0, 4'b0100, 1, 0, 0, 2, 4'b0000, "single_src");
    for (int i = 0; i < 3; i++) add(0, 4'b0110, 0, 0, 0, 2, 4'b0000, "dwell_restart");
`ifdef SEG7_AUTOSCROLL_EN
    add(0, 4'b0110, 0, 0, 0, 1, 4'b0010, "dwell_adv");
`else
    add(0, 4'b0110, 0, 0, 0, 2, 4'b0000, "no_auto");
`endif
    // Source drops
    add(1, 4'b0000, 0, 0, 1, 0, 4'b0000, "reset3");
    add(0, 4'b1011, 0, 0, 0, 0, 4'b0001, "drop_first");
    add(0, 4'b1011, 0, 0, 0, 0, 4'b0000, "drop_mid");
    add(0, 4'b1010, 0, 0, 0, 1, 4'b0010, "drop_adv");
    add(0, 4'b0000, 0, 0, 1, 0, 4'b0000, "drop_all");

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
        check_show($sformatf("%s[%0d]", tbl[i].name, i), 1'b1, 0, 4'b0000);
        check($sformatf("%s[%0d].cur", tbl[i].name, i), 64'(cur_src), 64'(0));
      end else begin
        src_valid = tbl[i].vld;
        btn_next  = tbl[i].btn;
        freeze    = tbl[i].frz;
        step();
        btn_next  = 1'b0;
        freeze    = 1'b0;
        check_show($sformatf("%s[%0d]", tbl[i].name, i), tbl[i].blank, tbl[i].src, tbl[i].ack);
      end
    end

    // Alert over source 2: six cycles, payload latched, return without ack
    do_reset();
    src_valid = 4'b0100;
    step();
    check_show("al_pre", 1'b0, 2, 4'b0100);
    alert_data = A1; alert_mode = SEG7_MODE_HEX; alert_req = 1'b1;
    step();
    alert_req = 1'b0; alert_data = '0; alert_mode = 1'b1;
    for (int i = 0; i < ALERT_HOLD; i++) begin
      check_alert($sformatf("al_hold%0d", i), A1, SEG7_MODE_HEX);
      if (i < ALERT_HOLD - 1) step();
    end
    step();
    check_show("al_ret", 1'b0, 2, 4'b0000);

    // Re-alert in the third alert cycle: nine alert cycles in total
    alert_data = A2; alert_mode = 1'b1; alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_alert($sformatf("re_first%0d", i), A2, 1'b1);
      if (i < 2) step();
    end
    alert_data = A3; alert_mode = 1'b0; alert_req = 1'b1;
    for (int i = 0; i < ALERT_HOLD; i++) begin
      step();
      alert_req = 1'b0;
      check_alert($sformatf("re_second%0d", i), A3, 1'b0);
    end
    step();
    check_show("re_ret", 1'b0, 2, 4'b0000);

    // btn_next dismisses an alert on the next cycle
    alert_data = A4; alert_mode = 1'b1; alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    check_alert("dis_on", A4, 1'b1);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check_show("dis_ret", 1'b0, 2, 4'b0000);

    // alert_req beats btn_next in the same cycle
    alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    check_alert("pri_on", A4, 1'b1);
    alert_data = A5; alert_mode = 1'b0; alert_req = 1'b1; btn_next = 1'b1;
    step();
    alert_req = 1'b0; btn_next = 1'b0;
    check_alert("pri_req_wins", A5, 1'b0);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check_show("pri_ret", 1'b0, 2, 4'b0000);

    // Alert exit after the current source dropped advances with ack
    alert_data = A2; alert_mode = 1'b1; alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    check_alert("xadv_on", A2, 1'b1);
    src_valid = 4'b0001; btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check_show("xadv_ret", 1'b0, 0, 4'b0001);

    // Asynchronous reset in the middle of an alert
    src_valid = 4'b0110;
    alert_data = A3; alert_mode = 1'b0; alert_req = 1'b1;
    step();
    alert_req = 1'b0;
    check_alert("mrst_on", A3, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check_show("mrst_blank", 1'b1, 0, 4'b0000);
    check("mrst_blank.cur", 64'(cur_src), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    check_show("mrst_restart", 1'b0, 1, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
